// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: byte-serial load/store controller in front of an 8-bit synchronous RAM
module lsu_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_misbranch,
    input  logic              in_ld_req,
    input  logic [2:0]        in_ld_size,
    input  logic [ADDR_W-1:0] in_ld_addr,
    input  logic              in_ld_signed,
    output logic              out_ld_done,
    output logic [DATA_W-1:0] out_ld_data,
    input  logic              in_st_req,
    input  logic [2:0]        in_st_size,
    input  logic [ADDR_W-1:0] in_st_addr,
    input  logic [DATA_W-1:0] in_st_data,
    output logic              out_st_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);
    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;
    state_t state;
    logic ld_pend, ld_sg, st_pend, wr_q, a_v, d_v, resync;
    logic [2:0] ld_sz, st_sz, ld_i, ld_k, st_i;
    logic [ADDR_W-1:0] ld_ad, st_ad, ld_a_n, st_a_n;
    logic [DATA_W-1:0] st_dat, buf_q, nb, ext, st_d_n;
    logic [7:0] sb;
    logic ld_new, ld_take, st_take, st_go, ld_go, ld_sg_n;
    logic [2:0] ld_sz_n, st_sz_n;

    function automatic logic [2:0] dec(input logic [2:0] s);
        return (s == 3'd1) ? 3'd1 : (s == 3'd2) ? 3'd2 : 3'd4;
    endfunction

    assign ld_new  = in_ld_req && !in_misbranch;
    assign ld_take = ld_new && !ld_pend && state != LOAD;
    assign st_take = in_st_req && !st_pend && state != STORE;
    assign st_go   = st_pend || in_st_req;
    assign ld_go   = (ld_pend || in_ld_req) && !in_misbranch;
    assign ld_a_n  = ld_pend ? ld_ad : in_ld_addr;
    assign ld_sz_n = ld_pend ? ld_sz : dec(in_ld_size);
    assign ld_sg_n = ld_pend ? ld_sg : in_ld_signed;
    assign st_a_n  = st_pend ? st_ad : in_st_addr;
    assign st_sz_n = st_pend ? st_sz : dec(in_st_size);
    assign st_d_n  = st_pend ? st_dat : in_st_data;
    assign nb      = buf_q | (DATA_W'(mem_din) << {ld_k, 3'b000});
    assign ext     = (ld_sz == 3'd1) ? {{(DATA_W-8){ld_sg && nb[7]}}, nb[7:0]} :
                     (ld_sz == 3'd2) ? {{(DATA_W-16){ld_sg && nb[15]}}, nb[15:0]} : nb;
    assign sb      = 8'(st_dat >> {st_i, 3'b000});
    assign mem_wr  = wr_q && rdy;

    // request slots, arbitration and the load/store sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ld_pend <= 1'b0;
            st_pend <= 1'b0;
            ld_sg <= 1'b0;
            ld_sz <= 3'd0;
            st_sz <= 3'd0;
            ld_ad <= '0;
            st_ad <= '0;
            st_dat <= '0;
            ld_i <= 3'd0;
            ld_k <= 3'd0;
            st_i <= 3'd0;
            a_v <= 1'b0;
            d_v <= 1'b0;
            resync <= 1'b0;
            buf_q <= '0;
            wr_q <= 1'b0;
            out_ld_done <= 1'b0;
            out_st_done <= 1'b0;
            out_ld_data <= '0;
            mem_a <= '0;
            mem_dout <= 8'd0;
        end else begin
            out_ld_done <= 1'b0;
            out_st_done <= 1'b0;
            if (!rdy) begin
                resync <= resync || state == LOAD;
            end else begin
                if (ld_take) begin
                    ld_pend <= 1'b1;
                    ld_ad <= in_ld_addr;
                    ld_sz <= dec(in_ld_size);
                    ld_sg <= in_ld_signed;
                end
                if (st_take) begin
                    st_pend <= 1'b1;
                    st_ad <= in_st_addr;
                    st_sz <= dec(in_st_size);
                    st_dat <= in_st_data;
                end
                if (in_misbranch) ld_pend <= 1'b0;
                case (state)
                    IDLE: begin
                        if (st_go) begin
                            state <= STORE;
                            st_pend <= 1'b0;
                            st_ad <= st_a_n;
                            st_sz <= st_sz_n;
                            st_dat <= st_d_n;
                            mem_a <= st_a_n;
                            mem_dout <= st_d_n[7:0];
                            wr_q <= 1'b1;
                            st_i <= 3'd1;
                        end else if (ld_go) begin
                            state <= LOAD;
                            ld_pend <= 1'b0;
                            ld_ad <= ld_a_n;
                            ld_sz <= ld_sz_n;
                            ld_sg <= ld_sg_n;
                            mem_a <= ld_a_n;
                            ld_i <= 3'd1;
                            ld_k <= 3'd0;
                            a_v <= 1'b1;
                            d_v <= 1'b0;
                            buf_q <= '0;
                            resync <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (in_misbranch) begin
                            state <= IDLE;
                        end else if (resync) begin
                            resync <= 1'b0;
                            mem_a <= ld_ad + ADDR_W'(ld_k);
                            ld_i <= ld_k + 3'd1;
                            a_v <= 1'b1;
                            d_v <= 1'b0;
                        end else begin
                            d_v <= a_v;
                            a_v <= ld_i != ld_sz;
                            if (ld_i != ld_sz) begin
                                mem_a <= ld_ad + ADDR_W'(ld_i);
                                ld_i <= ld_i + 3'd1;
                            end
                            if (d_v) begin
                                buf_q <= nb;
                                ld_k <= ld_k + 3'd1;
                                if (ld_k == ld_sz - 3'd1) begin
                                    out_ld_data <= ext;
                                    out_ld_done <= 1'b1;
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                    STORE: begin
                        if (st_i == st_sz) begin
                            wr_q <= 1'b0;
                            out_st_done <= 1'b1;
                            state <= IDLE;
                        end else begin
                            mem_a <= st_ad + ADDR_W'(st_i);
                            mem_dout <= sb;
                            st_i <= st_i + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: table-driven loads plus scoreboarded corner sequences for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
    logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, in_misbranch = 1'b0;
    logic in_ld_req = 1'b0, in_ld_signed = 1'b0, in_st_req = 1'b0;
    logic [2:0] in_ld_size = 3'd0, in_st_size = 3'd0;
    logic [31:0] in_ld_addr = '0, in_st_addr = '0, in_st_data = '0;
    logic out_ld_done, out_st_done, mem_wr;
    logic [31:0] out_ld_data, mem_a;
    logic [7:0] mem_din = 8'd0, mem_dout;
    logic [7:0] ram [4096];
    logic pk_we = 1'b0;
    logic [11:0] pk_a = '0;
    logic [7:0] pk_d = '0;
    int cyc = 0, n_cmp = 0, n_bad = 0, wr_in_stall = 0, ld_done_cnt = 0, st_done_cnt = 0;

    typedef struct { logic [31:0] data; int lat; int t0; } exp_t;
    typedef struct { logic [31:0] a; logic [2:0] sz; logic sg; logic [31:0] exp; int lat; } vec_t;
    exp_t ldq[$], stq[$];
    vec_t tbl[10];

    lsu_mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_misbranch(in_misbranch),
        .in_ld_req(in_ld_req), .in_ld_size(in_ld_size), .in_ld_addr(in_ld_addr),
        .in_ld_signed(in_ld_signed), .out_ld_done(out_ld_done), .out_ld_data(out_ld_data),
        .in_st_req(in_st_req), .in_st_size(in_st_size), .in_st_addr(in_st_addr),
        .in_st_data(in_st_data), .out_st_done(out_st_done), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // edge counter used to measure latency in edges
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit synchronous RAM model with a bench-side preload port
    always @(posedge clk) begin
        if (pk_we) ram[pk_a] <= pk_d;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // scoreboard: pop the expected result whenever a done pulse appears
    always @(negedge clk) begin
        exp_t e;
        if (mem_wr && !rdy) wr_in_stall++;
        if (out_ld_done && out_st_done) chk("done_overlap", 32'd1, 32'd0);
        if (out_ld_done) begin
            ld_done_cnt++;
            if (ldq.size() == 0) chk("ld_unexpected", 32'd1, 32'd0);
            else begin
                e = ldq.pop_front();
                chk("ld_data", out_ld_data, e.data);
                chk("ld_lat", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
        if (out_st_done) begin
            st_done_cnt++;
            if (stq.size() == 0) chk("st_unexpected", 32'd1, 32'd0);
            else begin
                e = stq.pop_front();
                chk("st_lat", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pk_we = 1'b1; pk_a = a; pk_d = d;
        tick();
        pk_we = 1'b0;
    endtask

    task automatic put_ld(input logic [31:0] a, input logic [2:0] sz, input logic sg);
        in_ld_req = 1'b1; in_ld_addr = a; in_ld_size = sz; in_ld_signed = sg;
    endtask

    task automatic put_st(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        in_st_req = 1'b1; in_st_addr = a; in_st_size = sz; in_st_data = d;
    endtask

    task automatic exp_ld(input logic [31:0] d, input int lat);
        ldq.push_back('{d, lat, cyc + 1});
    endtask

    task automatic exp_st(input int lat);
        stq.push_back('{32'd0, lat, cyc + 1});
    endtask

    task automatic fire();
        tick();
        in_ld_req = 1'b0; in_st_req = 1'b0; in_misbranch = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && (ldq.size() != 0 || stq.size() != 0); i++) tick();
        if (ldq.size() != 0 || stq.size() != 0) begin
            chk("timeout_pending", 32'(ldq.size() + stq.size()), 32'd0);
            ldq.delete();
            stq.delete();
        end
        tick();
        tick();
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_ld_done"}, 32'(out_ld_done), 32'd0);
        chk({nm, "_ld_data"}, out_ld_data, 32'd0);
        chk({nm, "_st_done"}, 32'(out_st_done), 32'd0);
        chk({nm, "_mem_wr"}, 32'(mem_wr), 32'd0);
        chk({nm, "_mem_a"}, mem_a, 32'd0);
        chk({nm, "_mem_dout"}, 32'(mem_dout), 32'd0);
    endtask

    initial begin
        int base;
        tbl[0] = '{32'h0000_0100, 3'd4, 1'b0, 32'h1234_5678, 5};
        tbl[1] = '{32'h0000_0020, 3'd1, 1'b1, 32'hFFFF_FF80, 2};
        tbl[2] = '{32'h0000_0020, 3'd1, 1'b0, 32'h0000_0080, 2};
        tbl[3] = '{32'h0000_0040, 3'd2, 1'b1, 32'hFFFF_F234, 3};
        tbl[4] = '{32'h0000_0040, 3'd2, 1'b0, 32'h0000_F234, 3};
        tbl[5] = '{32'h0000_0101, 3'd2, 1'b1, 32'h0000_3456, 3};
        tbl[6] = '{32'hFFFF_FFFF, 3'd2, 1'b0, 32'h0000_2211, 3};
        tbl[7] = '{32'h0000_0100, 3'd3, 1'b0, 32'h1234_5678, 5};
        tbl[8] = '{32'h0000_0102, 3'd1, 1'b1, 32'h0000_0034, 2};
        tbl[9] = '{32'h0000_0100, 3'd0, 1'b1, 32'h1234_5678, 5};
        poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
        poke(12'h020, 8'h80); poke(12'h040, 8'h34); poke(12'h041, 8'hF2);
        poke(12'hFFF, 8'h11); poke(12'h000, 8'h22); poke(12'h202, 8'h5A);
        poke(12'h703, 8'h00);
        chk_reset_outs("reset");
        rst = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            put_ld(tbl[i].a, tbl[i].sz, tbl[i].sg);
            exp_ld(tbl[i].exp, tbl[i].lat);
            fire();
            wait_idle();
        end
        put_st(32'h200, 3'd2, 32'hAABB_CCDD);
        exp_st(2);
        fire();
        wait_idle();
        chk("sh_b0", 32'(ram[12'h200]), 32'hDD);
        chk("sh_b1", 32'(ram[12'h201]), 32'hCC);
        chk("sh_b2_untouched", 32'(ram[12'h202]), 32'h5A);
        put_ld(32'h200, 3'd2, 1'b0);
        exp_ld(32'h0000_CCDD, 3);
        fire();
        wait_idle();
        put_st(32'h300, 3'd7, 32'h0102_0304);
        exp_st(4);
        fire();
        wait_idle();
        put_ld(32'h300, 3'd4, 1'b0);
        exp_ld(32'h0102_0304, 5);
        fire();
        wait_idle();
        put_ld(32'h10, 3'd4, 1'b0);
        put_st(32'h10, 3'd4, 32'hCAFE_BABE);
        exp_st(4);
        exp_ld(32'hCAFE_BABE, 10);
        fire();
        wait_idle();
        base = ld_done_cnt;
        put_ld(32'h100, 3'd4, 1'b0);
        fire();
        in_misbranch = 1'b1;
        fire();
        for (int i = 0; i < 12; i++) tick();
        chk("mb_abort_no_done", 32'(ld_done_cnt - base), 32'd0);
        base = ld_done_cnt;
        put_ld(32'h100, 3'd4, 1'b0);
        fire();
        for (int i = 0; i < 4; i++) tick();
        in_misbranch = 1'b1;
        fire();
        for (int i = 0; i < 8; i++) tick();
        chk("mb_final_no_done", 32'(ld_done_cnt - base), 32'd0);
        base = ld_done_cnt;
        put_st(32'h400, 3'd4, 32'hDEAD_BEEF);
        put_ld(32'h100, 3'd4, 1'b0);
        exp_st(4);
        fire();
        in_misbranch = 1'b1;
        fire();
        wait_idle();
        for (int i = 0; i < 8; i++) tick();
        chk("mb_pending_no_done", 32'(ld_done_cnt - base), 32'd0);
        chk("mb_st_word", {ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]}, 32'hDEAD_BEEF);
        put_ld(32'h100, 3'd4, 1'b0);
        exp_ld(32'h1234_5678, 5);
        fire();
        tick();
        put_st(32'h600, 3'd1, 32'h0000_00A5);
        exp_st(5);
        fire();
        wait_idle();
        chk("pend_st_byte", 32'(ram[12'h600]), 32'hA5);
        put_ld(32'h100, 3'd4, 1'b0);
        exp_ld(32'h1234_5678, 9);
        fire();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rdy = 1'b1;
        wait_idle();
        put_st(32'h500, 3'd4, 32'h1122_3344);
        exp_st(7);
        fire();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rdy = 1'b1;
        wait_idle();
        chk("stall_st_word", {ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]}, 32'h1122_3344);
        chk("no_wr_in_stall", 32'(wr_in_stall), 32'd0);
        base = st_done_cnt;
        put_st(32'h700, 3'd4, 32'h9988_7766);
        fire();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outs("midrst");
        for (int i = 0; i < 8; i++) tick();
        chk("midrst_no_st_done", 32'(st_done_cnt - base), 32'd0);
        chk("midrst_b0_written", 32'(ram[12'h700]), 32'h66);
        chk("midrst_b3_untouched", 32'(ram[12'h703]), 32'h00);
        put_ld(32'h100, 3'd4, 1'b0);
        exp_ld(32'h1234_5678, 5);
        fire();
        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

- Byte-serial memory controller: the responder side of the load-buffer memory request port, and the sink for committed stores from the reorder buffer.
- Accepts single-cycle load requests (address, size 1/2/4, signed flag). It reads the bytes one per cycle from the 8-bit synchronous RAM, assembles them little-endian, sign- or zero-extends, and returns the word with a one-cycle done pulse.
- Also serialises committed stores into byte writes.
- Sits between the load/store buffer, the ROB commit path and the RAM port.

## Interface
- ADDR_W, 32, RAM address width.
- DATA_W, 32, data word width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- rdy  in  1  global ready; low = stall (see Timing).
- in_misbranch  in  1  pipeline flush; kills loads only.
- in_ld_req  in  1  load request pulse.
- in_ld_size  in  3  bytes: 1, 2 or 4.
- in_ld_addr  in  ADDR_W  byte address.
- in_ld_signed  in  1  1 = sign-extend (sizes 1/2).
- out_ld_done  out  1  one-cycle pulse, load data valid.
- out_ld_data  out  DATA_W  extended load result.
- in_st_req  in  1  committed store pulse.
- in_st_size  in  3  bytes: 1, 2 or 4.
- in_st_addr  in  ADDR_W  byte address.
- in_st_data  in  DATA_W  store value; low bytes used.
- out_st_done  out  1  one-cycle pulse, store fully written.
- mem_din  in  8  RAM read data.
- mem_dout  out  8  RAM write data.
- mem_a  out  ADDR_W  RAM address.
- mem_wr  out  1  RAM write enable.

## Operation
- **RAM model.**
  - Write: the address and data presented with mem_wr=1 in a cycle are written at the closing edge.
  - Read: the byte for the address presented in a cycle is on mem_din during the next cycle.
- **Pending slots.**
  - One load slot and one store slot latch request pulses.
  - A request arriving while its own slot is occupied or being serviced is dropped. Requesters guarantee one outstanding request each.
- **FSM states:** IDLE, LOAD, STORE.
- **Arbitration in IDLE.** A pending or same-edge store wins over a load, because stores are architecturally older. Otherwise a pending or same-edge load starts. Requests are serviced directly from IDLE with no extra latch cycle.
- **LOAD.**
  - Issue counter i drives mem_a = addr+i for i = 0..size-1.
  - Capture counter stores mem_din into byte lane k for k = 0..size-1, one cycle behind issue.
  - On the final capture: out_ld_data is the assembled value; for size 1/2, bits above are filled with the top data bit if signed, else zero. out_ld_done pulses; state returns to IDLE.
- **STORE.**
  - mem_wr=1, mem_a = addr+i, mem_dout = in_st_data[8i+7:8i] for i = 0..size-1.
  - After the last byte: mem_wr=0, out_st_done pulses, state returns to IDLE.
- **Size encoding.** Size values other than 1 or 2 are treated as 4.
- **Address arithmetic.** addr+i wraps modulo 2^ADDR_W.
- **in_misbranch=1 with rdy=1:**
  - Clears the load slot and aborts LOAD (state goes to IDLE). No out_ld_done that edge, even if the final byte would complete.
  - A same-edge load request is dropped.
  - The store slot and an in-progress STORE are unaffected and complete normally.

## Timing
- **Reset values.** out_ld_done=0, out_ld_data=0, out_st_done=0, mem_wr=0, mem_a=0, mem_dout=0. State IDLE, both slots empty.
- All outputs are registered except the rdy gating of mem_wr.
- **Load latency.** Request sampled at edge T0 with the controller in IDLE: mem_a=addr from T0, and out_ld_done is high for the cycle after edge T(size+1).
  - LB: done after T2.
  - LW: done after T5.
  - The next transaction starts at T(size+2) at the earliest.
- **Store latency.** Request sampled at T0: bytes are written at T1..T(size); out_st_done is high for the cycle after T(size).
- out_ld_done and out_st_done are never high together and never high for two consecutive cycles for the same request.
- **rdy=0 (stall).**
  - All registers hold and mem_wr is forced to 0 combinationally.
  - Request pulses arriving during the stall are ignored; requesters must hold them off.
  - If stalled in LOAD, the first cycle after rdy returns re-presents mem_a = addr+captured and captures nothing. Normal issue/capture then resumes, so each load costs one extra cycle per stall episode.
- **Reset mid-operation.** The operation is abandoned immediately. No done pulse; a partial store stays partially written.

## Test plan
- **LW, unsigned.** RAM[0x100..0x103]=0x78,0x56,0x34,0x12; ld_req addr 0x100 size 4 -> out_ld_data=0x12345678, done exactly 5 edges after the request edge.
- **LB / LBU.** RAM[0x20]=0x80: LB signed -> 0xFFFFFF80. Same address unsigned -> 0x00000080. LH signed at 0x40 with bytes 0x34,0xF2 -> 0xFFFFF234.
- **SH store.** st_req addr 0x200 size 2 data 0xAABBCCDD -> RAM[0x200]=0xDD, RAM[0x201]=0xCC, 0x202 untouched; st_done after T2. A following LH unsigned from 0x200 returns 0x0000CCDD.
- **Simultaneous requests.** ld_req (0x10, size 4) and st_req (0x10, size 4, 0xCAFEBABE) on the same edge -> the store finishes first; the load then returns 0xCAFEBABE.
- **Misbranch.** Misbranch asserted on the edge after ld_req (LW) -> no out_ld_done ever. A store in flight at the same time still gives st_done and correct RAM contents.
- **Stall.** rdy dropped for 3 cycles mid-LW -> result still correct, done delayed by 4 cycles, no writes during the stall.
